// File: rtl/fm_cmd_pkg.sv
// Shared constants for the FM command player: host register map, CTRL/status
// bit positions, FSM encoding and command-entry layout.
package fm_cmd_pkg;

  // Host register indices
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_PUSH = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  // CTRL write bits
  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_FLUSH   = 1;
  localparam int unsigned CTRL_CLR_OVF = 2;

  // CTRL read (status) bits
  localparam int unsigned STAT_ENABLE    = 0;
  localparam int unsigned STAT_BUSY      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_FULL      = 3;
  localparam int unsigned STAT_OVF       = 4;
  localparam int unsigned STAT_COUNT_LSB = 8;

  // Command entry layout: {delay[15:0], addr[7:0], data[31:0]}
  localparam int unsigned ENTRY_W         = 56;
  localparam int unsigned ENTRY_DATA_LSB  = 0;
  localparam int unsigned ENTRY_ADDR_LSB  = 32;
  localparam int unsigned ENTRY_DELAY_LSB = 40;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StWrite = 2'd2
  } fsm_state_e;

  // Build a FIFO entry from a PUSH word and the latched data word.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic [31:0] push_word,
                                                    input logic [31:0] data);
    logic [ENTRY_W-1:0] entry;
    entry = '0;
    entry[ENTRY_DELAY_LSB +: 16] = push_word[23:8];
    entry[ENTRY_ADDR_LSB +: 8]   = push_word[7:0];
    entry[ENTRY_DATA_LSB +: 32]  = data;
    return entry;
  endfunction

endpackage

// File: rtl/fm_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding timed register writes.
// Pushes while full and any push/pop coinciding with flush are ignored.
module fm_cmd_fifo
  import fm_cmd_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned WIDTH      = ENTRY_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wrdata,
  output logic [WIDTH-1:0]      rddata,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0]   DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2:0]   CntOne   = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DepthCnt);
  assign count  = count_q;
  assign rddata = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers/occupancy.
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wrdata;
  end

endmodule

// File: rtl/fm_cmd_player.sv
// Host-queued, sample-tick-timed register write player driving the FM synth
// register port. Holds the host register decode, tick generator and FSM.
module fm_cmd_player
  import fm_cmd_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned TICK_DIV   = 506
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wrdata,
  input  logic        cpu_wren,
  output logic [31:0] cpu_rddata,
  output logic [7:0]  fm_addr,
  output logic [31:0] fm_wrdata,
  output logic        fm_wren,
  input  logic        fm_wait,
  output logic        irq_empty
);

  localparam int unsigned      TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [TickW-1:0] TickOne  = TickW'(1);

  logic [31:0]        data_q, data_d;
  logic               enable_q, enable_d;
  logic               overflow_q, overflow_d;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic               tick;
  fsm_state_e         state_q, state_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [7:0]         work_addr_q, work_addr_d;
  logic [31:0]        work_data_q, work_data_d;

  logic               wr_data, wr_push, wr_ctrl, flush;
  logic               fifo_pop, fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] fifo_rddata;
  logic [DEPTH_LOG2:0] fifo_count;
  logic [7:0]         count8;
  logic               busy;
  logic [15:0]        head_delay;

  assign wr_data    = cpu_wren & (cpu_addr == REG_DATA);
  assign wr_push    = cpu_wren & (cpu_addr == REG_PUSH);
  assign wr_ctrl    = cpu_wren & (cpu_addr == REG_CTRL);
  assign flush      = wr_ctrl & cpu_wrdata[CTRL_FLUSH];
  assign head_delay = fifo_rddata[ENTRY_DELAY_LSB +: 16];

  fm_cmd_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (wr_push),
    .pop    (fifo_pop),
    .flush  (flush),
    .wrdata (make_entry(cpu_wrdata, data_q)),
    .rddata (fifo_rddata),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  // Host-visible registers: data latch, enable and sticky overflow.
  always_comb begin
    data_d     = data_q;
    enable_d   = enable_q;
    overflow_d = overflow_q;
    if (wr_data) data_d = cpu_wrdata;
    if (wr_ctrl) enable_d = cpu_wrdata[CTRL_ENABLE];
    if (wr_push && fifo_full && !flush) overflow_d = 1'b1;
    if (wr_ctrl && cpu_wrdata[CTRL_CLR_OVF]) overflow_d = 1'b0;
  end

  // Free-running sample tick divider, independent of enable.
  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickOne;
  end

  // Player FSM. enable_d is used so a CTRL write takes effect on the edge
  // that captures it, giving one cycle from enable to fm_wren.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    work_addr_d = work_addr_q;
    work_data_d = work_data_q;
    fifo_pop    = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable_d && !fifo_empty) begin
            work_addr_d = fifo_rddata[ENTRY_ADDR_LSB +: 8];
            work_data_d = fifo_rddata[ENTRY_DATA_LSB +: 32];
            remaining_d = head_delay;
            state_d     = (head_delay == 16'd0) ? StWrite : StDelay;
          end
        end
        StDelay: begin
          if (enable_d && tick) begin
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) state_d = StWrite;
          end
        end
        StWrite: begin
          // Enable is deliberately ignored here: a started write completes.
          if (!fm_wait) begin
            fifo_pop = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      tick_cnt_q  <= '0;
      state_q     <= StIdle;
      remaining_q <= '0;
      work_addr_q <= '0;
      work_data_q <= '0;
    end else begin
      data_q      <= data_d;
      enable_q    <= enable_d;
      overflow_q  <= overflow_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      work_addr_q <= work_addr_d;
      work_data_q <= work_data_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign fm_wren   = (state_q == StWrite);
  assign fm_addr   = work_addr_q;
  assign fm_wrdata = work_data_q;
  assign irq_empty = enable_q & fifo_empty & ~busy;

  // Combinational host read mux.
  always_comb begin
    cpu_rddata = '0;
    count8     = '0;
    count8[DEPTH_LOG2:0] = fifo_count;
    case (cpu_addr)
      REG_DATA: cpu_rddata = data_q;
      REG_CTRL: begin
        cpu_rddata[STAT_ENABLE]             = enable_q;
        cpu_rddata[STAT_BUSY]               = busy;
        cpu_rddata[STAT_EMPTY]              = fifo_empty;
        cpu_rddata[STAT_FULL]               = fifo_full;
        cpu_rddata[STAT_OVF]                = overflow_q;
        cpu_rddata[STAT_COUNT_LSB +: 8]     = count8;
      end
      default: cpu_rddata = '0;
    endcase
  end

endmodule

// File: tb/tb_fm_cmd_player.sv
// Directed self-checking bench for fm_cmd_player.
module tb_fm_cmd_player;
  import fm_cmd_pkg::*;

  localparam int unsigned TickDiv = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cpu_addr = 2'd3;
  logic [31:0] cpu_wrdata = '0;
  logic        cpu_wren = 1'b0;
  logic [31:0] cpu_rddata;
  logic [7:0]  fm_addr;
  logic [31:0] fm_wrdata;
  logic        fm_wren;
  logic        fm_wait = 1'b0;
  logic        irq_empty;

  fm_cmd_player #(
    .DEPTH_LOG2 (5),
    .TICK_DIV   (TickDiv)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wrdata (cpu_wrdata),
    .cpu_wren   (cpu_wren),
    .cpu_rddata (cpu_rddata),
    .fm_addr    (fm_addr),
    .fm_wrdata  (fm_wrdata),
    .fm_wren    (fm_wren),
    .fm_wait    (fm_wait),
    .irq_empty  (irq_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference tick model, cycle counter and accepted-write log.
  int m_cnt, tick_total, cyc;
  int wren_cycles = 0;
  logic [7:0]  acc_addr [$];
  logic [31:0] acc_data [$];
  int          acc_time [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; tick_total <= 0; cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_cnt == TickDiv - 1) begin
        m_cnt <= 0; tick_total <= tick_total + 1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (fm_wren) wren_cycles <= wren_cycles + 1;
      if (fm_wren && !fm_wait) begin
        acc_addr.push_back(fm_addr);
        acc_data.push_back(fm_wrdata);
        acc_time.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive a one-cycle host write; returns 1 time unit after the capturing edge.
  task automatic host_wr(input logic [1:0] a, input logic [31:0] d);
    cpu_addr = a; cpu_wrdata = d; cpu_wren = 1'b1;
    @(posedge clk); #1;
    cpu_wren = 1'b0; cpu_addr = 2'd3;
  endtask

  task automatic host_rd(input logic [1:0] a, output logic [31:0] d);
    cpu_addr = a; #1;
    d = cpu_rddata;
    cpu_addr = 2'd3;
  endtask

  task automatic push_cmd(input logic [31:0] data, input logic [31:0] word);
    host_wr(REG_DATA, data);
    host_wr(REG_PUSH, word);
  endtask

  task automatic wait_busy(output bit ok);
    logic [31:0] v;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      host_rd(REG_CTRL, v);
      if (v[STAT_BUSY]) ok = 1; else step();
    end
  endtask

  task automatic wait_wren(input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (fm_wren) ok = 1; else step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    bit ok;
    int base, base_w, t0, t1, t2, notbusy, unstable, seen;

    // Reset values
    #12;
    check("rst_fm_wren", fm_wren, 0);
    check("rst_fm_addr", fm_addr, 0);
    check("rst_fm_wrdata", fm_wrdata, 0);
    check("rst_irq", irq_empty, 0);
    host_rd(REG_CTRL, v);
    check("rst_status", v, 32'h4);
    host_rd(REG_DATA, v);
    check("rst_data", v, 0);
    #7 reset = 1'b0;
    step();

    // Single zero-delay write
    push_cmd(32'h3, 32'h2);
    host_rd(REG_CTRL, v);
    check("t1_status_queued", v, 32'h100);
    host_wr(REG_CTRL, 32'h1);
    check("t1_wren", fm_wren, 1);
    check("t1_addr", fm_addr, 8'h02);
    check("t1_data", fm_wrdata, 32'h3);
    step(); step();
    check("t1_wren_low", fm_wren, 0);
    check("t1_pulse_cycles", wren_cycles, 1);
    check("t1_acc_count", acc_addr.size(), 1);
    check("t1_acc_entry", {acc_addr[0], acc_data[0]}, {8'h02, 32'h3});
    check("t1_irq", irq_empty, 1);
    host_rd(REG_CTRL, v);
    check("t1_status_done", v, 32'h5);

    // Delay of 3 ticks
    push_cmd(32'hAB, 32'h0000_0310);
    wait_busy(ok);
    check("t2_enter_delay", ok, 1);
    t0 = tick_total;
    notbusy = 0;
    wait_wren(5 * TickDiv, ok);
    check("t2_wren_seen", ok, 1);
    check("t2_ticks", tick_total - t0, 3);
    step(); step();
    check("t2_acc", {acc_addr[acc_addr.size()-1], acc_data[acc_data.size()-1]},
          {8'h10, 32'hAB});

    // fm_wait stall for 10 cycles
    fm_wait = 1'b1;
    push_cmd(32'h1234_5678, 32'h21);
    push_cmd(32'hCAFE_0001, 32'h22);
    wait_wren(20, ok);
    check("t3_wren_seen", ok, 1);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!fm_wren || fm_addr !== 8'h21 || fm_wrdata !== 32'h1234_5678) unstable++;
    end
    check("t3_stable", unstable, 0);
    host_rd(REG_CTRL, v);
    check("t3_count_stalled", v[15:8], 2);
    base = acc_addr.size();
    fm_wait = 1'b0;
    step();
    check("t3_one_accept", acc_addr.size(), base + 1);
    host_rd(REG_CTRL, v);
    check("t3_count_after", v[15:8], 1);
    check("t3_acc_first", {acc_addr[base], acc_data[base]}, {8'h21, 32'h1234_5678});
    repeat (4) step();
    check("t3_acc_count", acc_addr.size(), base + 2);
    check("t3_acc_second", {acc_addr[base+1], acc_data[base+1]}, {8'h22, 32'hCAFE_0001});

    // Overflow and in-order drain
    host_wr(REG_CTRL, 32'h0);
    for (int i = 0; i < 33; i++) push_cmd(32'hD000_0000 | i, i);
    host_rd(REG_CTRL, v);
    check("t4_full_ovf", v, 32'h2018);
    host_wr(REG_CTRL, 32'h4);
    host_rd(REG_CTRL, v);
    check("t4_ovf_clr", v, 32'h2008);
    base = acc_addr.size();
    host_wr(REG_CTRL, 32'h1);
    for (int i = 0; i < 200 && acc_addr.size() < base + 32; i++) step();
    check("t4_drain_count", acc_addr.size(), base + 32);
    if (acc_addr.size() >= base + 32) begin
      for (int i = 0; i < 32; i++)
        check("t4_drain_order", {acc_addr[base+i], acc_data[base+i]},
              {8'(i), 32'hD000_0000 | i});
      check("t4_throughput", acc_time[base+31] - acc_time[base], 62);
    end
    repeat (4) step();
    check("t4_no_extra", acc_addr.size(), base + 32);
    host_rd(REG_CTRL, v);
    check("t4_status_end", v, 32'h5);

    // Flush during DELAY
    for (int i = 0; i < 5; i++) push_cmd(32'hE000_0000 | i, 32'h0500 | (32'h40 + i));
    host_rd(REG_CTRL, v);
    check("t5_status_queued", v, 32'h0503);
    base_w = wren_cycles;
    base = acc_addr.size();
    host_wr(REG_CTRL, 32'h3);
    host_rd(REG_CTRL, v);
    check("t5_status_flushed", v, 32'h5);
    repeat (8 * TickDiv) step();
    check("t5_no_wren", wren_cycles, base_w);
    check("t5_no_accept", acc_addr.size(), base);

    // Disable during DELAY with remaining=2, then re-enable
    push_cmd(32'h6666_0001, 32'h0000_0450);
    wait_busy(ok);
    check("t6_enter_delay", ok, 1);
    t0 = tick_total;
    for (int i = 0; i < 5 * TickDiv && (tick_total - t0) < 2; i++) step();
    host_wr(REG_CTRL, 32'h0);
    t1 = tick_total;
    seen = 0;
    for (int i = 0; i < 6 * TickDiv && (tick_total - t1) < 4; i++) begin
      step();
      if (fm_wren) seen++;
    end
    check("t6_frozen_no_wren", seen, 0);
    host_rd(REG_CTRL, v);
    check("t6_status_frozen", v, 32'h0102);
    t2 = tick_total;
    host_wr(REG_CTRL, 32'h1);
    wait_wren(5 * TickDiv, ok);
    check("t6_wren_seen", ok, 1);
    check("t6_ticks_after", tick_total - t2, 2);
    step(); step();
    check("t6_acc", {acc_addr[acc_addr.size()-1], acc_data[acc_data.size()-1]},
          {8'h50, 32'h6666_0001});

    // Disable during WRITE still completes
    fm_wait = 1'b1;
    push_cmd(32'h7777_0002, 32'h0000_0060);
    wait_wren(10, ok);
    check("t7_wren_seen", ok, 1);
    host_wr(REG_CTRL, 32'h0);
    base = acc_addr.size();
    fm_wait = 1'b0;
    step();
    check("t7_accept", acc_addr.size(), base + 1);
    check("t7_acc_addr", acc_addr[acc_addr.size()-1], 8'h60);
    step();
    check("t7_wren_low", fm_wren, 0);
    host_rd(REG_CTRL, v);
    check("t7_status", v, 32'h4);
    check("t7_irq_disabled", irq_empty, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fm_cmd_player.md
Name: fm_cmd_player

Overview:
- Bus initiator that drives the FM synthesizer's register write port (addr/wrdata/wren, with a wait handshake), the opposite end of that interface.
- Host CPU queues timed register writes into a FIFO. The player issues each write after a programmed delay counted in audio sample ticks.
- Gives sample-accurate note/parameter sequencing without CPU timing loops.
- Sits between the CPU I/O decoder and the synth bus port.

Parameters:
- DEPTH_LOG2, 5, log2 of command FIFO depth (32 entries); range 2..7.
- TICK_DIV, 506, clk cycles per sample tick; matches the synth sample rate.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  2  host register select
- cpu_wrdata  in  32  host write data
- cpu_wren  in  1  host write strobe, single cycle
- cpu_rddata  out  32  host read data, combinational from cpu_addr
- fm_addr  out  8  synth register address
- fm_wrdata  out  32  synth write data
- fm_wren  out  1  synth write request
- fm_wait  in  1  synth stall; a write is accepted in a cycle with fm_wren=1 and fm_wait=0
- irq_empty  out  1  level, 1 when enabled, FIFO empty and state IDLE

Behaviour:
- Reset values: all outputs 0, FIFO empty, enable=0, overflow=0, state IDLE, tick counter 0, latched data 0.
- Host register map:
  - 0 (DATA): write latches the 32-bit data word; read returns the latch.
  - 1 (PUSH): write pushes entry {delay=wrdata[23:8], addr=wrdata[7:0], data=latch}. Reads 0.
  - 2 (CTRL): write bit0 sets enable; write bit1=1 flushes; write bit2=1 clears overflow. Read returns {16'b0, count[7:0], 3'b0, overflow, full, empty, busy, enable}. busy = (state != IDLE).
  - 3: reads 0, writes ignored.
- PUSH while full: entry dropped, overflow set (sticky).
- PUSH and pop in the same cycle: count unchanged, both take effect.
- Tick generator: free-running counter 0..TICK_DIV-1, independent of enable. tick is a 1-cycle pulse when the counter wraps to 0.
- FSM states IDLE, DELAY, WRITE:
  - IDLE: if enable and !empty, load head entry into the working registers. Go to WRITE if delay==0, else DELAY with remaining=delay.
  - DELAY: on tick, remaining decrements; when remaining hits 0, go to WRITE. If enable=0, remaining freezes and the state holds.
  - WRITE: fm_wren=1, fm_addr/fm_wrdata driven from the working registers and held stable while fm_wait=1. On the accept cycle: pop FIFO, go to IDLE, fm_wren=0 from the next cycle.
- Throughput:
  - Back-to-back zero-delay entries: one accepted write per 2 cycles (WRITE, IDLE).
  - Enable with a non-empty FIFO to first fm_wren: 1 cycle.
- Disable during WRITE: the write still completes. Only IDLE and DELAY honour enable.
- Flush (any state): FIFO emptied, state IDLE, fm_wren=0 the next cycle. Entry not popped twice. Overflow unaffected. A simultaneous PUSH is discarded.
- Delay semantics: the first decrement occurs on the first tick after entering DELAY. Actual wait is delay ticks, with up to TICK_DIV-1 cycles of phase jitter.
- delay=0xFFFF is a valid delay; no wrap issues.
- Width rules:
  - count is DEPTH_LOG2+1 bits, zero-extended into the 8-bit read field.
  - FIFO pointers wrap modulo 2^DEPTH_LOG2.
- Reset mid-write drops the transaction. fm_wren falls asynchronously.

Decomposition:
- Package fm_cmd_pkg: host register indices (REG_DATA=0, REG_PUSH=1, REG_CTRL=2), CTRL bit positions, FSM state encodings, entry field offsets (entry width 56).
- Sub-module fm_cmd_fifo:
  - Synchronous FIFO, width 56, depth 2^DEPTH_LOG2, first-word-fall-through head output.
  - Ports: push, pop, flush, wrdata, rddata, empty, full, count.
- Top level holds the register decode, tick generator and FSM.

Test Plan:
- Sequence: DATA=0x0000_0003, PUSH=0x0000_0002, CTRL=1, fm_wait=0 -> one cycle later a single fm_wren pulse with fm_addr=0x02, fm_wrdata=3; then irq_empty=1 and status empty=1.
- PUSH delay=3 (wrdata=0x0000_0300 | addr) -> fm_wren asserted only after exactly 3 tick pulses following entry to DELAY; busy=1 throughout.
- fm_wait held high for 10 cycles during WRITE -> fm_wren, fm_addr and fm_wrdata stable all 10 cycles; pop occurs only on the first fm_wait=0 cycle; count decrements by 1.
- Push 33 entries with DEPTH_LOG2=5 while disabled -> full=1, count=32, overflow=1. CTRL bit2 clears overflow. Enabling then drains all 32 in FIFO order.
- Flush during DELAY with 5 entries queued -> next cycle state IDLE, count=0, no fm_wren ever asserted.
- CTRL=0 during DELAY with remaining=2 across 4 ticks, then re-enable -> write issued after 2 further ticks. Disable during WRITE still completes that write.
